// File: rtl/snake_game_fsm.sv
// Snake game sequencer: owns the snake body, its length, the food cell and
// the game-state flags. One cell of movement per Tick; eat, wall and self
// collisions are resolved in the Tick cycle, and new food is found by a
// linear probe starting from a random candidate.
module snake_game_fsm #(
    parameter logic [7:0] START_POS = 8'h88,
    parameter logic [7:0] FOOD_INIT = 8'h8C,
    parameter int         WIN_LEN   = 15
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Start,
    input  logic         Tick,
    input  logic         BtnU,
    input  logic         BtnD,
    input  logic         BtnL,
    input  logic         BtnR,
    input  logic [7:0]   Rand,
    output logic [127:0] Locations_Flat,
    output logic [3:0]   Length,
    output logic [7:0]   Food,
    output logic         Qi,
    output logic         Qc,
    output logic         Ql,
    output logic         Qw
);

    typedef enum logic [2:0] {S_INIT, S_RUN, S_PLACE, S_LOSE, S_WIN} state_t;
    // Opposite directions differ only in bit 0.
    typedef enum logic [1:0] {DIR_U = 2'b00, DIR_D = 2'b01, DIR_L = 2'b10, DIR_R = 2'b11} dir_t;

    state_t     state_q, state_d;
    dir_t       dir_q, dir_d;
    logic [7:0] loc_q [16];
    logic [7:0] loc_d [16];
    logic [3:0] len_q, len_d;
    logic [7:0] food_q, food_d;
    logic [7:0] cand_q, cand_d;

    logic [7:0] nh;
    logic       eat, wall, self_hit, cand_hit, btn_any;
    logic [4:0] hit_limit;
    dir_t       btn_dir;

    function automatic logic is_opposite(dir_t a, dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    function automatic logic hits_wall(logic [7:0] h, dir_t d);
        case (d)
            DIR_U:   return h[7:4] == 4'd0;
            DIR_D:   return h[7:4] == 4'd15;
            DIR_L:   return h[3:0] == 4'd0;
            default: return h[3:0] == 4'd15;
        endcase
    endfunction

    function automatic logic [7:0] step_cell(logic [7:0] h, dir_t d);
        case (d)
            DIR_U:   return h - 8'd16;
            DIR_D:   return h + 8'd16;
            DIR_L:   return h - 8'd1;
            default: return h + 8'd1;
        endcase
    endfunction

    // Next-state logic: direction latch, move/collision resolution, food search.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        loc_d   = loc_q;
        len_d   = len_q;
        food_d  = food_q;
        cand_d  = cand_q;

        nh        = step_cell(loc_q[0], dir_q);
        wall      = hits_wall(loc_q[0], dir_q);
        eat       = (nh == food_q);
        // Without eating, the tail cell vacates during the move and is legal.
        hit_limit = eat ? {1'b0, len_q} : ({1'b0, len_q} - 5'd1);
        self_hit  = 1'b0;
        cand_hit  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if ((5'(i) < hit_limit) && (loc_q[i] == nh)) self_hit = 1'b1;
            if ((5'(i) < {1'b0, len_q}) && (loc_q[i] == cand_q)) cand_hit = 1'b1;
        end

        btn_any = BtnU | BtnD | BtnL | BtnR;
        if (BtnU)      btn_dir = DIR_U;
        else if (BtnD) btn_dir = DIR_D;
        else if (BtnL) btn_dir = DIR_L;
        else           btn_dir = DIR_R;

        // The move below uses dir_q, so a press in a Tick cycle waits a Tick.
        if ((state_q == S_RUN || state_q == S_PLACE) && btn_any &&
            !((len_q > 4'd1) && is_opposite(btn_dir, dir_q)))
            dir_d = btn_dir;

        case (state_q)
            S_INIT: begin
                if (Start) state_d = S_RUN;
            end
            S_RUN: begin
                if (Tick) begin
                    if (wall || self_hit) begin
                        state_d = S_LOSE;
                    end else begin
                        for (int i = 15; i > 0; i--) loc_d[i] = loc_q[i-1];
                        loc_d[0] = nh;
                        if (eat) begin
                            len_d  = len_q + 4'd1;
                            cand_d = Rand;
                            if (({1'b0, len_q} + 5'd1) == 5'(WIN_LEN)) state_d = S_WIN;
                            else                                         state_d = S_PLACE;
                        end
                    end
                end
            end
            S_PLACE: begin
                if (cand_hit) begin
                    cand_d = cand_q + 8'd1;
                end else begin
                    food_d  = cand_q;
                    state_d = S_RUN;
                end
            end
            default: begin
                if (Start) begin
                    state_d = S_INIT;
                    dir_d   = DIR_R;
                    len_d   = 4'd1;
                    food_d  = FOOD_INIT;
                    for (int i = 1; i < 16; i++) loc_d[i] = 8'h00;
                    loc_d[0] = START_POS;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= S_INIT;
            dir_q   <= DIR_R;
            len_q   <= 4'd1;
            food_q  <= FOOD_INIT;
            cand_q  <= 8'h00;
            for (int i = 1; i < 16; i++) loc_q[i] <= 8'h00;
            loc_q[0] <= START_POS;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            food_q  <= food_d;
            cand_q  <= cand_d;
            loc_q   <= loc_d;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign Locations_Flat[8*(15-g) +: 8] = loc_q[g];
    end

    assign Length = len_q;
    assign Food   = food_q;
    assign Qi     = (state_q == S_INIT);
    assign Qc     = (state_q == S_RUN) || (state_q == S_PLACE);
    assign Ql     = (state_q == S_LOSE);
    assign Qw     = (state_q == S_WIN);

endmodule

// File: tb/tb_snake_game_fsm.sv
// Testbench for snake_game_fsm: directed game scenarios, a queue-based game
// model compared every cycle, and literal expectations at key points.
module tb_snake_game_fsm;

    logic         Clk = 1'b0;
    logic         Reset_n, Start, Tick, BtnU, BtnD, BtnL, BtnR;
    logic [7:0]   Rand;
    logic [127:0] Locations_Flat;
    logic [3:0]   Length;
    logic [7:0]   Food;
    logic         Qi, Qc, Ql, Qw;

    int total = 0;
    int bad   = 0;

    snake_game_fsm dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Tick(Tick),
        .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .Rand(Rand),
        .Locations_Flat(Locations_Flat), .Length(Length), .Food(Food),
        .Qi(Qi), .Qc(Qc), .Ql(Ql), .Qw(Qw)
    );

    always #5 Clk = ~Clk;

    // Game model: mode 0 init, 1 playing, 2 searching food, 3 lost, 4 won.
    int m_mode;
    int m_body[$];
    int m_food;
    int m_dr, m_dc;
    int m_cnt, m_pf;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_init();
        m_mode = 0;
        m_body.delete();
        m_body.push_back(136);
        m_food = 140;
        m_dr = 0;
        m_dc = 1;
        m_cnt = 0;
    endtask

    function automatic bit in_body(int c, int n);
        for (int j = 0; j < n; j++) if (m_body[j] == c) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_buttons();
        int ndr, ndc;
        if (!(BtnU || BtnD || BtnL || BtnR)) return;
        if (BtnU)      begin ndr = -1; ndc = 0;  end
        else if (BtnD) begin ndr = 1;  ndc = 0;  end
        else if (BtnL) begin ndr = 0;  ndc = -1; end
        else           begin ndr = 0;  ndc = 1;  end
        if (m_body.size() > 1 && ndr == -m_dr && ndc == -m_dc) return;
        m_dr = ndr;
        m_dc = ndc;
    endtask

    task automatic model_move();
        int r, c, nh, n, cand, k;
        bit eat;
        r = m_body[0] / 16 + m_dr;
        c = m_body[0] % 16 + m_dc;
        if (r < 0 || r > 15 || c < 0 || c > 15) begin
            m_mode = 3;
            return;
        end
        nh  = r * 16 + c;
        eat = (nh == m_food);
        n   = eat ? m_body.size() : m_body.size() - 1;
        if (in_body(nh, n)) begin
            m_mode = 3;
            return;
        end
        m_body.push_front(nh);
        if (!eat) begin
            void'(m_body.pop_back());
            return;
        end
        if (m_body.size() == 15) begin
            m_mode = 4;
            return;
        end
        cand = int'(Rand);
        k = 1;
        while (in_body(cand, m_body.size())) begin
            cand = (cand + 1) % 256;
            k++;
        end
        m_pf   = cand;
        m_cnt  = k;
        m_mode = 2;
    endtask

    task automatic model_step();
        if (!Reset_n) begin
            model_init();
            return;
        end
        case (m_mode)
            0: if (Start) m_mode = 1;
            1: begin
                if (Tick) model_move();
                if (m_mode == 1 || m_mode == 2) model_buttons();
            end
            2: begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_food = m_pf;
                    m_mode = 1;
                end
                model_buttons();
            end
            default: if (Start) model_init();
        endcase
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge Clk) begin
        if (chk_en) begin
            logic [127:0] e, mk;
            e  = '0;
            mk = '0;
            for (int j = 0; j < m_body.size(); j++) begin
                e[127-8*j -: 8]  = 8'(m_body[j]);
                mk[127-8*j -: 8] = 8'hFF;
            end
            check("m_qi", 128'(Qi), 128'(m_mode == 0));
            check("m_qc", 128'(Qc), 128'(m_mode == 1 || m_mode == 2));
            check("m_ql", 128'(Ql), 128'(m_mode == 3));
            check("m_qw", 128'(Qw), 128'(m_mode == 4));
            check("m_len", 128'(Length), 128'(m_body.size()));
            check("m_food", 128'(Food), 128'(m_food));
            check("m_body", Locations_Flat & mk, e);
        end
    end

    task automatic cyc();
        @(posedge Clk);
        model_step();
        #2;
        Start = 1'b0;
        Tick  = 1'b0;
        BtnU  = 1'b0;
        BtnD  = 1'b0;
        BtnL  = 1'b0;
        BtnR  = 1'b0;
    endtask

    logic [7:0] path [17];

    initial begin
        path = '{8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F, 8'h9F, 8'hAF,
                 8'hBF, 8'hCF, 8'hDF, 8'hEF, 8'hFF, 8'hFE, 8'hFD, 8'hFC};
        Reset_n = 1'b0; Start = 1'b0; Tick = 1'b0;
        BtnU = 1'b0; BtnD = 1'b0; BtnL = 1'b0; BtnR = 1'b0;
        Rand = 8'h8C;

        // Reset held for two cycles
        cyc(); cyc();
        chk_en = 1'b1;
        check("rst_qi", 128'(Qi), 128'(1));
        check("rst_len", 128'(Length), 128'(1));
        check("rst_lf", Locations_Flat, {8'h88, 120'h0});
        check("rst_food", 128'(Food), 128'h8C);

        // Start, four moves right, eat at 8C, food search skips 8C
        Reset_n = 1'b1;
        Start = 1'b1; cyc();
        check("start_qc", 128'(Qc), 128'(1));
        for (int k = 0; k < 4; k++) begin
            Tick = 1'b1; cyc();
            check("t2_head", 128'(Locations_Flat[127:120]), 128'(8'(8'h89 + k)));
            cyc();
        end
        cyc();
        check("t2_food", 128'(Food), 128'h8D);
        check("t2_len", 128'(Length), 128'(2));
        check("t2_body", 128'(Locations_Flat[127:112]), 128'h8C8B);

        // Reversal dropped at Length 2 (eats 8D); then U beats R
        Rand = 8'h20;
        BtnL = 1'b1; cyc();
        Tick = 1'b1; cyc();
        check("rev_head", 128'(Locations_Flat[127:120]), 128'h8D);
        cyc(); cyc();
        check("rev_food", 128'(Food), 128'h20);
        BtnU = 1'b1; BtnR = 1'b1; cyc();
        Tick = 1'b1; cyc();
        check("prio_head", 128'(Locations_Flat[127:120]), 128'h7D);
        cyc();

        // Wall at column 15 moving right
        BtnR = 1'b1; cyc();
        Tick = 1'b1; cyc();
        Tick = 1'b1; cyc();
        check("wall_pre", 128'(Locations_Flat[127:120]), 128'h7F);
        Tick = 1'b1; cyc();
        check("wall_ql", 128'(Ql), 128'(1));
        check("wall_body", 128'(Locations_Flat[127:104]), 128'h7F7E7D);
        check("wall_len", 128'(Length), 128'(3));
        BtnD = 1'b1; Tick = 1'b1; cyc();
        check("lose_frozen", 128'(Locations_Flat[127:104]), 128'h7F7E7D);
        Start = 1'b1; cyc();
        check("reinit_qi", 128'(Qi), 128'(1));
        check("reinit_lf", Locations_Flat, {8'h88, 120'h0});
        check("reinit_food", 128'(Food), 128'h8C);

        // Grow to the winning length along row 8, column 15, then row 15
        Start = 1'b1; cyc();
        for (int p = 0; p < 17; p++) begin
            if (path[p] == 8'h9F) begin BtnD = 1'b1; cyc(); end
            if (path[p] == 8'hFE) begin BtnL = 1'b1; cyc(); end
            Rand = (p < 16) ? path[p+1] : 8'h00;
            Tick = 1'b1; cyc();
            cyc(); cyc();
            if (path[p] == 8'hFD) check("len14", 128'(Length), 128'(14));
        end
        check("win_len", 128'(Length), 128'(15));
        check("win_qw", 128'(Qw), 128'(1));
        Tick = 1'b1; cyc();
        BtnU = 1'b1; Tick = 1'b1; cyc();
        check("win_frozen_len", 128'(Length), 128'(15));
        check("win_frozen_head", 128'(Locations_Flat[127:120]), 128'hFC);
        check("win_frozen_qw", 128'(Qw), 128'(1));

        // Start+Tick in INIT, then reset in the middle of a colliding food search
        Reset_n = 1'b0; cyc();
        Reset_n = 1'b1;
        Start = 1'b1; Tick = 1'b1; cyc();
        check("st_tick_head", 128'(Locations_Flat[127:120]), 128'h88);
        check("st_tick_qc", 128'(Qc), 128'(1));
        Rand = 8'h8B;
        for (int k = 0; k < 4; k++) begin
            Tick = 1'b1; cyc();
            if (k < 3) cyc();
        end
        Reset_n = 1'b0; cyc();
        check("abort_qi", 128'(Qi), 128'(1));
        check("abort_food", 128'(Food), 128'h8C);
        check("abort_len", 128'(Length), 128'(1));
        Reset_n = 1'b1;
        cyc(); cyc();
        check("abort_stay_qi", 128'(Qi), 128'(1));
        check("abort_stay_food", 128'(Food), 128'h8C);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
